// File: rtl/data_buffer.sv
// First-word-fall-through buffer with valid/ready handshakes on both sides.
// It has configurable width and depth, an occupancy count, full/empty flags
// and a synchronous clear. Every output depends only on registered state.
module data_buffer #(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 2,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [Width-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [Width-1:0] o_data,
    output logic [CntW-1:0]  o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_c;
    logic             pop_c;

    // Advance a pointer by one and wrap from Depth-1 back to zero.
    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
        if (ptr == PtrW'(Depth - 1)) begin
            return '0;
        end
        return PtrW'(ptr + 1'b1);
    endfunction

    // Status flags come from the registered count only, so ready never depends on i_ready.
    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == CntW'(Depth));
    assign o_ready = ~o_full;
    assign o_valid = ~o_empty;
    assign o_count = count_q;
    assign o_data  = o_valid ? mem_q[rd_ptr_q] : '0;

    // Handshake qualification: a full buffer refuses writes even while it is being popped.
    assign push_c = i_valid & o_ready;
    assign pop_c  = o_valid & i_ready;

    // Next-state for the pointers, the count and the storage. Clear overrides push and pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                mem_d[wr_ptr_q] = i_data;
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (pop_c) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            if (push_c && !pop_c) begin
                count_d = CntW'(count_q + 1'b1);
            end else if (pop_c && !push_c) begin
                count_d = CntW'(count_q - 1'b1);
            end
        end
    end

    // Control state register with synchronous reset. Reset takes priority over clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array. It has no reset because empty entries are never presented on o_data.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_data_buffer.sv
// Directed testbench for data_buffer at Width=8, Depth=4, plus a Depth=1 instance.
module tb_data_buffer;

    localparam int unsigned W = 8;
    localparam int unsigned D = 4;

    logic         clk;
    logic         rst;
    logic         clear;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [2:0]   count;
    logic         full;
    logic         empty;

    logic         s_clear;
    logic         s_in_valid;
    logic         s_out_ready;
    logic [W-1:0] s_in_data;
    logic         s_in_ready;
    logic         s_out_valid;
    logic [W-1:0] s_out_data;
    logic [0:0]   s_count;
    logic         s_full;
    logic         s_empty;

    int tests;
    int fails;
    logic [W-1:0] q[$];

    data_buffer #(.Width(W), .Depth(D)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clear (clear),
        .i_valid (in_valid),
        .o_ready (out_ready),
        .i_data  (in_data),
        .o_valid (out_valid),
        .i_ready (in_ready),
        .o_data  (out_data),
        .o_count (count),
        .o_full  (full),
        .o_empty (empty)
    );

    data_buffer #(.Width(W), .Depth(1)) dut1 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clear (s_clear),
        .i_valid (s_in_valid),
        .o_ready (s_out_ready),
        .i_data  (s_in_data),
        .o_valid (s_out_valid),
        .i_ready (s_in_ready),
        .o_data  (s_out_data),
        .o_count (s_count),
        .o_full  (s_full),
        .o_empty (s_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hAB; in_ready = 1'b0; clear = 1'b0;
        tick();
        tick();
        rst = 1'b0; in_valid = 1'b0;
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b exp 1", empty); end
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %b exp 0", full); end
        tests++; if (out_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", out_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL reset_data got %h exp 00", out_data); end
    endtask

    task automatic test_fill();
        logic [W-1:0] words [4];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
        in_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = words[i];
            tick();
            tests++;
            if (count !== 3'(i + 1)) begin fails++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i + 1); end
            tests++;
            if (out_valid !== 1'b1 || out_data !== 8'h11) begin
                fails++; $display("FAIL fill_head[%0d] got v=%b d=%h exp v=1 d=11", i, out_valid, out_data);
            end
        end
        tests++; if (full !== 1'b1) begin fails++; $display("FAIL fill_full got %b exp 1", full); end
        tests++; if (out_ready !== 1'b0) begin fails++; $display("FAIL fill_ready got %b exp 0", out_ready); end
        in_data = 8'h55;
        tick();
        in_valid = 1'b0;
        tests++; if (count !== 3'd4) begin fails++; $display("FAIL refuse_count got %0d exp 4", count); end
        tests++; if (out_data !== 8'h11) begin fails++; $display("FAIL refuse_head got %h exp 11", out_data); end
    endtask

    task automatic test_drain_wrap();
        logic [W-1:0] exp_order [8];
        logic [W-1:0] nxt;
        int got;
        int cyc;
        exp_order[0] = 8'h11; exp_order[1] = 8'h22; exp_order[2] = 8'h33; exp_order[3] = 8'h44;
        exp_order[4] = 8'hA0; exp_order[5] = 8'hA1; exp_order[6] = 8'hA2; exp_order[7] = 8'hA3;
        q = {8'h11, 8'h22, 8'h33, 8'h44};
        nxt = 8'hA0;
        got = 0;
        cyc = 0;
        while (got < 8 && cyc < 40) begin
            tests++;
            if (out_ready !== (q.size() < D)) begin
                fails++; $display("FAIL drain_ready cyc %0d got %b exp %b", cyc, out_ready, q.size() < D);
            end
            tests++;
            if (q.size() > 0 && out_data !== exp_order[got]) begin
                fails++; $display("FAIL drain_order[%0d] got %h exp %h", got, out_data, exp_order[got]);
            end
            in_ready = 1'b1;
            in_valid = (nxt <= 8'hA3);
            in_data  = nxt;
            if (q.size() > 0) begin
                void'(q.pop_front());
                got++;
            end
            if (in_valid && q.size() + ((got > 0) ? 0 : 0) < D && cyc > 0) begin
                q.push_back(nxt);
                nxt = nxt + 8'h01;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0; in_ready = 1'b0;
        tests++; if (got !== 8) begin fails++; $display("FAIL drain_timeout got %0d words exp 8", got); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL drain_empty got %b exp 1", empty); end
    endtask

    task automatic test_simultaneous();
        in_valid = 1'b1; in_ready = 1'b0;
        in_data = 8'hB0; tick();
        in_data = 8'hB1; tick();
        tests++; if (count !== 3'd2) begin fails++; $display("FAIL simul_pre_count got %0d exp 2", count); end
        in_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            logic [W-1:0] e;
            e = (k == 0) ? 8'hB0 : (k == 1) ? 8'hB1 : W'(8'hC0 + k - 2);
            tests++;
            if (out_data !== e) begin fails++; $display("FAIL simul_data[%0d] got %h exp %h", k, out_data, e); end
            in_data = W'(8'hC0 + k);
            tick();
            tests++;
            if (count !== 3'd2) begin fails++; $display("FAIL simul_count[%0d] got %0d exp 2", k, count); end
        end
        in_valid = 1'b0;
        tests++; if (out_data !== 8'hC8) begin fails++; $display("FAIL simul_tail0 got %h exp c8", out_data); end
        tick();
        tests++; if (out_data !== 8'hC9) begin fails++; $display("FAIL simul_tail1 got %h exp c9", out_data); end
        tick();
        in_ready = 1'b0;
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL simul_empty got %b exp 1", empty); end
    endtask

    task automatic test_clear();
        in_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'h31; tick();
        in_data = 8'h32; tick();
        in_data = 8'h33; tick();
        tests++; if (count !== 3'd3) begin fails++; $display("FAIL clear_pre_count got %0d exp 3", count); end
        clear = 1'b1; in_data = 8'h77; in_ready = 1'b1;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL clear_count got %0d exp 0", count); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL clear_valid got %b exp 0", out_valid); end
        tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL clear_data got %h exp 00", out_data); end
        tick();
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL clear_absent got empty=%b exp 1", empty); end
        in_valid = 1'b1; in_data = 8'h88; in_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tests++; if (out_data !== 8'h88 || count !== 3'd1) begin
            fails++; $display("FAIL clear_after got d=%h c=%0d exp d=88 c=1", out_data, count);
        end
        in_ready = 1'b1; tick(); in_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_data = 8'h5C; tick(); tick();
        rst = 1'b1; clear = 1'b0; tick();
        rst = 1'b0; in_valid = 1'b0;
        tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_mid got c=%0d v=%b exp c=0 v=0", count, out_valid);
        end
    endtask

    task automatic test_depth1();
        s_clear = 1'b0; s_in_valid = 1'b1; s_in_data = 8'h5A; s_in_ready = 1'b0;
        tick();
        tests++; if (s_full !== 1'b1 || s_out_ready !== 1'b0 || s_out_data !== 8'h5A) begin
            fails++; $display("FAIL d1_fill got f=%b r=%b d=%h exp f=1 r=0 d=5a", s_full, s_out_ready, s_out_data);
        end
        s_in_data = 8'h6B; s_in_ready = 1'b1;
        tick();
        tests++; if (s_empty !== 1'b1 || s_count !== 1'b0) begin
            fails++; $display("FAIL d1_refuse got e=%b c=%0d exp e=1 c=0", s_empty, s_count);
        end
        s_in_ready = 1'b0;
        tick();
        s_in_valid = 1'b0;
        tests++; if (s_out_valid !== 1'b1 || s_out_data !== 8'h6B) begin
            fails++; $display("FAIL d1_push got v=%b d=%h exp v=1 d=6b", s_out_valid, s_out_data);
        end
    endtask

    task automatic test_random();
        bit do_push;
        bit do_pop;
        q.delete();
        for (int c = 0; c < 2000; c++) begin
            tests++;
            if (count !== 3'(q.size()) || out_valid !== (q.size() > 0) ||
                (q.size() > 0 && out_data !== q[0])) begin
                fails++;
                $display("FAIL rand[%0d] got c=%0d v=%b d=%h exp c=%0d d=%h", c, count, out_valid, out_data,
                         q.size(), (q.size() > 0) ? q[0] : 8'h00);
            end
            in_valid = 1'($urandom_range(0, 1));
            in_ready = 1'($urandom_range(0, 1));
            in_data  = W'($urandom);
            do_push = in_valid && (q.size() < D);
            do_pop  = in_ready && (q.size() > 0);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(in_data);
            tick();
        end
        in_valid = 1'b0; in_ready = 1'b0;
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_ready = 1'b0; in_data = '0;
        s_clear = 1'b0; s_in_valid = 1'b0; s_in_ready = 1'b0; s_in_data = '0;
        #1;
        test_reset();
        test_fill();
        test_drain_wrap();
        test_simultaneous();
        test_clear();
        test_reset_mid();
        test_depth1();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
